// File: rtl/sine_pwm_sequencer.sv
// Four-channel sine-modulated PWM sequencer.
// A free-running 64-cycle frame counter produces the PWM carrier. Once per
// PRESCALE frames the sine base index advances; during cycles 0..3 of every
// frame the shared external LUT is addressed once per channel (phase offset
// k*PHASE_STEP) and the result is shadowed, then promoted to the active duty
// at the frame end. A per-channel FSM gates the output, stepping only at
// frame ends.
//
// Optional build macro SINE_SEQ_ZC_GATE_EN: channels start and stop only when
// their sampled sine index is 0 (zero crossing), using ARMED/DRAIN states.
// Without it, channels start/stop directly at the next frame end.
//
// Ports:
//   sysclk      clock, all state updates on rising edge
//   rst_n       asynchronous active-low reset
//   en[3:0]     per-channel run request, sampled at frame end
//   lut_index   address to the shared combinational sine-duty LUT
//   lut_duty    LUT result for lut_index, same cycle (0..64)
//   pwm[3:0]    registered PWM outputs
//   running     channel in RUN or DRAIN
//   frame_sync  one-cycle pulse in the cycle after the frame counter reads 63
module sine_pwm_sequencer #(
    parameter int unsigned PRESCALE   = 1,
    parameter int unsigned PHASE_STEP = 16
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [3:0] en,
    output logic [5:0] lut_index,
    input  logic [6:0] lut_duty,
    output logic [3:0] pwm,
    output logic [3:0] running,
    output logic       frame_sync
);

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 6;
    localparam int unsigned DW  = 7;
    localparam int unsigned PW  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] base_q, base_d;
    logic [CW-1:0] lut_index_q, lut_index_d;
    logic          frame_end;
    logic          frame_sync_q;
    logic [NCH-1:0] pwm_q;
    logic [NCH-1:0] running_q;
    logic [DW-1:0] shadow_duty_q [NCH];
    logic [DW-1:0] active_duty_q [NCH];
`ifdef SINE_SEQ_ZC_GATE_EN
    logic [CW-1:0] shadow_idx_q  [NCH];
`endif
    state_e        state_q [NCH];
    state_e        state_d [NCH];

    // Next-state for counters, LUT address (registered one cycle ahead) and FSMs
    always_comb begin
        frame_end   = (cnt_q == CW'(63));
        cnt_d       = cnt_q + CW'(1);
        presc_d     = presc_q;
        base_d      = base_q;
        lut_index_d = '0;

        if (frame_end) begin
            if (presc_q == PW'(PRESCALE - 1)) begin
                presc_d = '0;
                base_d  = base_q + CW'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        // Address for the cycle the counter is about to enter
        if (cnt_d < CW'(NCH)) begin
            lut_index_d = base_d + CW'(PHASE_STEP * 32'(cnt_d[1:0]));
        end

        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
`ifdef SINE_SEQ_ZC_GATE_EN
                ST_IDLE:  if (en[k]) state_d[k] = ST_ARMED;
                ST_ARMED: begin
                    if (!en[k])                    state_d[k] = ST_IDLE;
                    else if (shadow_idx_q[k] == '0) state_d[k] = ST_RUN;
                end
                ST_RUN:   if (!en[k]) state_d[k] = ST_DRAIN;
                ST_DRAIN: begin
                    if (en[k])                     state_d[k] = ST_RUN;
                    else if (shadow_idx_q[k] == '0) state_d[k] = ST_IDLE;
                end
`else
                ST_IDLE:  if (en[k])  state_d[k] = ST_RUN;
                ST_RUN:   if (!en[k]) state_d[k] = ST_IDLE;
`endif
                default:  state_d[k] = ST_IDLE;
            endcase
        end
    end

    // State registers; captures in cycles 0..3, promotion and FSM step at frame end
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            presc_q      <= '0;
            base_q       <= '0;
            lut_index_q  <= '0;
            frame_sync_q <= 1'b0;
            pwm_q        <= '0;
            running_q    <= '0;
            for (int k = 0; k < NCH; k++) begin
                shadow_duty_q[k] <= '0;
                active_duty_q[k] <= '0;
`ifdef SINE_SEQ_ZC_GATE_EN
                shadow_idx_q[k]  <= '0;
`endif
                state_q[k]       <= ST_IDLE;
            end
        end else begin
            cnt_q        <= cnt_d;
            presc_q      <= presc_d;
            base_q       <= base_d;
            lut_index_q  <= lut_index_d;
            frame_sync_q <= frame_end;
            for (int k = 0; k < NCH; k++) begin
                if (cnt_q == CW'(k)) begin
                    shadow_duty_q[k] <= lut_duty;
`ifdef SINE_SEQ_ZC_GATE_EN
                    shadow_idx_q[k]  <= lut_index_q;
`endif
                end
                // running_q mirrors state_q in RUN/DRAIN
                pwm_q[k] <= running_q[k] && ({1'b0, cnt_q} < active_duty_q[k]);
                if (frame_end) begin
                    active_duty_q[k] <= shadow_duty_q[k];
                    state_q[k]       <= state_d[k];
                    running_q[k]     <= (state_d[k] == ST_RUN) || (state_d[k] == ST_DRAIN);
                end
            end
        end
    end

    assign lut_index  = lut_index_q;
    assign pwm        = pwm_q;
    assign running    = running_q;
    assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_sine_pwm_sequencer.sv
// Directed bench for sine_pwm_sequencer: default instance plus a PRESCALE=2
// instance sharing clock, reset and enables. LUT model: duty = {0, index}.
// Frame/cycle positions are tracked by a bench cycle counter reset with rst_n.
module tb_sine_pwm_sequencer;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic [3:0] en;
    logic [5:0] lut_index, lut_index2;
    logic [6:0] lut_duty, lut_duty2;
    logic [3:0] pwm, pwm2, running, running2;
    logic       frame_sync, frame_sync2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    always #5 sysclk = ~sysclk;

    assign lut_duty  = {1'b0, lut_index};
    assign lut_duty2 = {1'b0, lut_index2};

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    sine_pwm_sequencer u_dut (
        .sysclk(sysclk), .rst_n(rst_n), .en(en),
        .lut_index(lut_index), .lut_duty(lut_duty),
        .pwm(pwm), .running(running), .frame_sync(frame_sync)
    );

    sine_pwm_sequencer #(.PRESCALE(2), .PHASE_STEP(16)) u_dut_p2 (
        .sysclk(sysclk), .rst_n(rst_n), .en(en),
        .lut_index(lut_index2), .lut_duty(lut_duty2),
        .pwm(pwm2), .running(running2), .frame_sync(frame_sync2)
    );

    // Advance to negedge of frame f, counter value c (bounded)
    task automatic goto(input int f, input int c);
        int tgt;
        int n;
        tgt = f * 64 + c;
        n   = 0;
        while (cyc != tgt && n < 20000) begin
            @(negedge sysclk);
            n++;
        end
        if (cyc != tgt) begin
            n_cmp++;
            n_err++;
            $display("FAIL goto_timeout: at cycle %0d, wanted %0d", cyc, tgt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 4'b0000;
        repeat (3) @(negedge sysclk);
        n_cmp++; if (pwm !== 4'b0000)      begin n_err++; $display("FAIL reset_pwm: got %b want 0000", pwm); end
        n_cmp++; if (running !== 4'b0000)  begin n_err++; $display("FAIL reset_running: got %b want 0000", running); end
        n_cmp++; if (frame_sync !== 1'b0)  begin n_err++; $display("FAIL reset_frame_sync: got %b want 0", frame_sync); end
        n_cmp++; if (lut_index !== 6'd0)   begin n_err++; $display("FAIL reset_lut_index: got %0d want 0", lut_index); end
        n_cmp++; if (running2 !== 4'b0000) begin n_err++; $display("FAIL reset_running_p2: got %b want 0000", running2); end
        rst_n = 1'b1;
        goto(0, 1);
        n_cmp++; if (lut_index !== 6'd16) begin n_err++; $display("FAIL first_edge_index: got %0d want 16", lut_index); end
    endtask

    task automatic test_lut_index();
        int exp1;
        int exp2;
        for (int k = 0; k < 4; k++) begin
            goto(5, k);
            exp1 = (5 + 16 * k) % 64;
            exp2 = (2 + 16 * k) % 64;
            n_cmp++; if (lut_index !== 6'(exp1))  begin n_err++; $display("FAIL lut_index_cnt%0d: got %0d want %0d", k, lut_index, exp1); end
            n_cmp++; if (lut_index2 !== 6'(exp2)) begin n_err++; $display("FAIL lut_index_p2_cnt%0d: got %0d want %0d", k, lut_index2, exp2); end
        end
        goto(5, 4);
        n_cmp++; if (lut_index !== 6'd0) begin n_err++; $display("FAIL lut_index_cnt4: got %0d want 0", lut_index); end
        goto(5, 63);
        n_cmp++; if (lut_index !== 6'd0) begin n_err++; $display("FAIL lut_index_cnt63: got %0d want 0", lut_index); end
    endtask

    task automatic test_frame_sync();
        goto(6, 0);
        n_cmp++; if (frame_sync !== 1'b1)  begin n_err++; $display("FAIL frame_sync_cnt0: got %b want 1", frame_sync); end
        n_cmp++; if (frame_sync2 !== 1'b1) begin n_err++; $display("FAIL frame_sync_p2_cnt0: got %b want 1", frame_sync2); end
        goto(6, 1);
        n_cmp++; if (frame_sync !== 1'b0)  begin n_err++; $display("FAIL frame_sync_cnt1: got %b want 0", frame_sync); end
        goto(6, 63);
        n_cmp++; if (frame_sync !== 1'b0)  begin n_err++; $display("FAIL frame_sync_cnt63: got %b want 0", frame_sync); end
    endtask

    task automatic test_prescale(input int f);
        goto(f, 0);
        n_cmp++; if (lut_index !== 6'(f % 64))        begin n_err++; $display("FAIL presc1_base: got %0d want %0d", lut_index, f % 64); end
        n_cmp++; if (lut_index2 !== 6'((f / 2) % 64)) begin n_err++; $display("FAIL presc2_base_a: got %0d want %0d", lut_index2, (f / 2) % 64); end
        goto(f + 1, 0);
        n_cmp++; if (lut_index2 !== 6'((f / 2) % 64)) begin n_err++; $display("FAIL presc2_base_b: got %0d want %0d", lut_index2, (f / 2) % 64); end
        n_cmp++; if (frame_sync2 !== 1'b1)            begin n_err++; $display("FAIL presc2_frame_sync: got %b want 1", frame_sync2); end
        goto(f + 1, 1);
        n_cmp++; if (frame_sync2 !== 1'b0)            begin n_err++; $display("FAIL presc2_frame_sync_off: got %b want 0", frame_sync2); end
        goto(f + 2, 0);
        n_cmp++; if (lut_index2 !== 6'((f / 2 + 1) % 64)) begin n_err++; $display("FAIL presc2_base_c: got %0d want %0d", lut_index2, (f / 2 + 1) % 64); end
    endtask

    task automatic test_async_reset(input int g, input logic [3:0] exp_run, input logic [3:0] exp_pwm);
        goto(g, 30);
        n_cmp++; if (running !== exp_run) begin n_err++; $display("FAIL pre_reset_running: got %b want %b", running, exp_run); end
        n_cmp++; if (pwm !== exp_pwm)     begin n_err++; $display("FAIL pre_reset_pwm: got %b want %b", pwm, exp_pwm); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (running !== 4'b0000)  begin n_err++; $display("FAIL async_running: got %b want 0000", running); end
        n_cmp++; if (pwm !== 4'b0000)      begin n_err++; $display("FAIL async_pwm: got %b want 0000", pwm); end
        n_cmp++; if (running2 !== 4'b0000) begin n_err++; $display("FAIL async_running_p2: got %b want 0000", running2); end
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        goto(0, 1);
        n_cmp++; if (lut_index !== 6'd16)  begin n_err++; $display("FAIL restart_index: got %0d want 16", lut_index); end
        goto(0, 10);
        n_cmp++; if (running !== 4'b0000)  begin n_err++; $display("FAIL restart_running: got %b want 0000", running); end
        goto(0, 63);
        n_cmp++; if (frame_sync !== 1'b0)  begin n_err++; $display("FAIL restart_sync_cnt63: got %b want 0", frame_sync); end
        goto(1, 0);
        n_cmp++; if (frame_sync !== 1'b1)  begin n_err++; $display("FAIL restart_sync: got %b want 1", frame_sync); end
        n_cmp++; if (lut_index !== 6'd1)   begin n_err++; $display("FAIL restart_base: got %0d want 1", lut_index); end
        n_cmp++; if (lut_index2 !== 6'd0)  begin n_err++; $display("FAIL restart_base_p2: got %0d want 0", lut_index2); end
    endtask

`ifdef SINE_SEQ_ZC_GATE_EN
    task automatic test_zc_arm();
        goto(0, 10);
        en = 4'b0011;
        goto(1, 0);
        n_cmp++; if (running !== 4'b0000) begin n_err++; $display("FAIL zc_armed_not_running: got %b want 0000", running); end
    endtask

    task automatic test_zc_start();
        goto(48, 63);
        n_cmp++; if (running !== 4'b0000) begin n_err++; $display("FAIL zc_ch1_before: got %b want 0000", running); end
        goto(49, 0);
        n_cmp++; if (running !== 4'b0010) begin n_err++; $display("FAIL zc_ch1_start: got %b want 0010", running); end
        goto(49, 5);
        n_cmp++; if (pwm !== 4'b0000)     begin n_err++; $display("FAIL zc_ch1_duty0: got %b want 0000", pwm); end
        goto(50, 1);
        n_cmp++; if (pwm !== 4'b0010)     begin n_err++; $display("FAIL zc_ch1_duty1_hi: got %b want 0010", pwm); end
        goto(50, 2);
        n_cmp++; if (pwm !== 4'b0000)     begin n_err++; $display("FAIL zc_ch1_duty1_lo: got %b want 0000", pwm); end
        goto(64, 63);
        n_cmp++; if (running !== 4'b0010) begin n_err++; $display("FAIL zc_ch0_before: got %b want 0010", running); end
        goto(65, 0);
        n_cmp++; if (running !== 4'b0011) begin n_err++; $display("FAIL zc_ch0_start: got %b want 0011", running); end
        goto(65, 1);
        n_cmp++; if (pwm !== 4'b0010)     begin n_err++; $display("FAIL zc_pwm_f65: got %b want 0010", pwm); end
        goto(66, 1);
        n_cmp++; if (pwm !== 4'b0011)     begin n_err++; $display("FAIL zc_pwm_f66_c1: got %b want 0011", pwm); end
        goto(66, 2);
        n_cmp++; if (pwm !== 4'b0010)     begin n_err++; $display("FAIL zc_pwm_f66_c2: got %b want 0010", pwm); end
    endtask

    task automatic test_zc_stop();
        goto(100, 10);
        en = 4'b0010;
        goto(101, 0);
        n_cmp++; if (running !== 4'b0011) begin n_err++; $display("FAIL zc_drain_running: got %b want 0011", running); end
        goto(110, 10);
        n_cmp++; if (pwm !== 4'b0011)     begin n_err++; $display("FAIL zc_drain_pwm: got %b want 0011", pwm); end
        goto(128, 63);
        n_cmp++; if (running !== 4'b0011) begin n_err++; $display("FAIL zc_drain_end: got %b want 0011", running); end
        goto(129, 0);
        n_cmp++; if (running !== 4'b0010) begin n_err++; $display("FAIL zc_stopped: got %b want 0010", running); end
        goto(129, 5);
        n_cmp++; if (pwm !== 4'b0010)     begin n_err++; $display("FAIL zc_stopped_pwm: got %b want 0010", pwm); end
    endtask
`else
    task automatic test_direct_start();
        goto(3, 20);
        en = 4'b0100;
        goto(3, 63);
        n_cmp++; if (running !== 4'b0000) begin n_err++; $display("FAIL direct_before: got %b want 0000", running); end
        goto(4, 0);
        n_cmp++; if (running !== 4'b0100) begin n_err++; $display("FAIL direct_start: got %b want 0100", running); end
        goto(4, 1);
        n_cmp++; if (pwm !== 4'b0100)     begin n_err++; $display("FAIL direct_pwm_c1: got %b want 0100", pwm); end
        goto(4, 35);
        n_cmp++; if (pwm !== 4'b0100)     begin n_err++; $display("FAIL direct_pwm_c35: got %b want 0100", pwm); end
        goto(4, 36);
        n_cmp++; if (pwm !== 4'b0000)     begin n_err++; $display("FAIL direct_pwm_c36: got %b want 0000", pwm); end
    endtask

    task automatic test_direct_pwm();
        goto(7, 38);
        n_cmp++; if (pwm !== 4'b0100) begin n_err++; $display("FAIL duty38_c38: got %b want 0100", pwm); end
        goto(7, 39);
        n_cmp++; if (pwm !== 4'b0000) begin n_err++; $display("FAIL duty38_c39: got %b want 0000", pwm); end
    endtask

    task automatic test_glitch();
        goto(8, 10);
        en = 4'b0000;
        goto(8, 20);
        en = 4'b0100;
        goto(9, 0);
        n_cmp++; if (running !== 4'b0100) begin n_err++; $display("FAIL glitch_ignored: got %b want 0100", running); end
    endtask

    task automatic test_direct_stop();
        goto(10, 5);
        n_cmp++; if (pwm !== 4'b0100)     begin n_err++; $display("FAIL stop_pwm_before: got %b want 0100", pwm); end
        en = 4'b0000;
        goto(10, 63);
        n_cmp++; if (running !== 4'b0100) begin n_err++; $display("FAIL stop_running_before: got %b want 0100", running); end
        goto(11, 0);
        n_cmp++; if (running !== 4'b0000) begin n_err++; $display("FAIL stop_running: got %b want 0000", running); end
        goto(11, 5);
        n_cmp++; if (pwm !== 4'b0000)     begin n_err++; $display("FAIL stop_pwm: got %b want 0000", pwm); end
    endtask

    task automatic test_all_channels();
        goto(12, 3);
        en = 4'b1111;
        goto(12, 63);
        n_cmp++; if (running !== 4'b0000) begin n_err++; $display("FAIL all_before: got %b want 0000", running); end
        goto(13, 0);
        n_cmp++; if (running !== 4'b1111) begin n_err++; $display("FAIL all_start: got %b want 1111", running); end
        goto(14, 20);
        n_cmp++; if (pwm !== 4'b1110)     begin n_err++; $display("FAIL all_pwm_c20: got %b want 1110", pwm); end
        goto(14, 40);
        n_cmp++; if (pwm !== 4'b1100)     begin n_err++; $display("FAIL all_pwm_c40: got %b want 1100", pwm); end
        goto(14, 50);
        en = 4'b0000;
        goto(15, 0);
        n_cmp++; if (running !== 4'b0000) begin n_err++; $display("FAIL all_stop: got %b want 0000", running); end
        goto(15, 2);
        n_cmp++; if (pwm !== 4'b0000)     begin n_err++; $display("FAIL all_stop_pwm: got %b want 0000", pwm); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SINE_SEQ_ZC_GATE_EN
        test_zc_arm();
        test_lut_index();
        test_frame_sync();
        test_zc_start();
        test_zc_stop();
        test_prescale(130);
        test_async_reset(134, 4'b0010, 4'b0000);
`else
        test_direct_start();
        test_lut_index();
        test_frame_sync();
        test_direct_pwm();
        test_glitch();
        test_direct_stop();
        test_all_channels();
        test_prescale(20);
        goto(23, 10);
        en = 4'b1111;
        test_async_reset(24, 4'b1111, 4'b0110);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sine_pwm_sequencer.md
SINE_PWM_SEQUENCER -- requirements
Module: sine_pwm_sequencer

Interface
REQ-001 Parameter PRESCALE, default 1, number of 64-cycle PWM frames per sine-index step (1..255).
REQ-002 Parameter PHASE_STEP, default 16, sine-index offset between adjacent channels (0..63).
REQ-003 sysclk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  4  per-channel run request, level-sensitive.
REQ-006 lut_index  output  6  address to the shared external combinational sine-duty LUT.
REQ-007 lut_duty  input  7  LUT result for lut_index, same cycle, range 0..64.
REQ-008 pwm  output  4  registered per-channel PWM outputs.
REQ-009 running  output  4  channel k high in RUN or DRAIN.
REQ-010 frame_sync  output  1  registered one-cycle pulse for the cycle after the frame counter reads 63.

Function
REQ-011 6-bit frame counter cnt SHALL free-run 0..63 and wrap to 0.
REQ-012 A prescale counter SHALL advance once per frame end (cnt==63); base_idx (6-bit) SHALL increment mod 64 when it reaches PRESCALE-1, and the prescale counter SHALL then clear.
REQ-013 During cnt==k (k=0..3), lut_index SHALL equal (base_idx + k*PHASE_STEP) mod 64; lut_duty SHALL be captured into shadow_duty[k], and the index into shadow_idx[k], on that edge.
REQ-014 For cnt 4..63, lut_index SHALL be 0 and no capture SHALL occur.
REQ-015 At the cnt==63 edge, active_duty[k] SHALL load shadow_duty[k]; duty latency is therefore one frame.
REQ-016 pwm[k] SHALL register (state[k] in RUN or DRAIN) AND (cnt < active_duty[k]); duty 0 gives constant low, duty 64 constant high.
REQ-017 Per-channel FSM states: IDLE, ARMED, RUN, DRAIN; transitions SHALL occur only at the cnt==63 edge, at most one per frame.
REQ-018 IDLE: en[k]=1 -> ARMED; otherwise remain.
REQ-019 ARMED: en[k]=0 -> IDLE; else shadow_idx[k]==0 -> RUN; otherwise remain.
REQ-020 RUN: en[k]=0 -> DRAIN; otherwise remain.
REQ-021 DRAIN: en[k]=1 -> RUN; else shadow_idx[k]==0 -> IDLE; otherwise remain.
REQ-022 en changes between frame ends SHALL be ignored; only the value sampled at the cnt==63 edge counts.
REQ-023 Channels SHALL be independent; simultaneous transitions on all four channels SHALL be supported.

Reset
REQ-024 While rst_n low: cnt, prescale counter, base_idx, shadow and active registers = 0; all FSMs IDLE; pwm=0, running=0, frame_sync=0, lut_index=0.
REQ-025 Reset asserted mid-frame SHALL take effect immediately; after release, cnt SHALL start at 0 on the first edge.

Configuration
REQ-026 Macro SINE_SEQ_ZC_GATE_EN defined: zero-crossing-gated start/stop per REQ-018..021.
REQ-027 Macro undefined: IDLE with en=1 -> RUN, and RUN with en=0 -> IDLE, both at the next frame end; ARMED and DRAIN SHALL be unreachable and need not be encoded.

Verification
REQ-028 Bench LUT model lut_duty={1'b0,lut_index}, defaults: in frame 5, lut_index for cnt 0..3 = 5,21,37,53; 0 for cnt 4..63.
REQ-029 Macro on: en=4'b0001 raised in frame 0 -> ARMED at end of frame 0; running[0] rises at end of frame 64; first pwm[0] high pulse in frame 66 (duty 1).
REQ-030 Macro on: en[1] raised in frame 0 -> running[1] rises at end of frame 48 (shadow_idx[1]=(48+16) mod 64=0).
REQ-031 Macro on: ch0 running, en[0] dropped in frame 100 -> running[0] stays high until end of frame 128, then pwm[0]=0.
REQ-032 Macro off: en[2] raised in frame 3 -> running[2] at end of frame 3; dropped in frame 10 -> running[2]=0 and pwm[2]=0 after end of frame 10.
REQ-033 PRESCALE=2: base_idx increments every 128 cycles; frame_sync every 64 cycles; rst_n pulsed at cnt=30 clears all outputs asynchronously and restarts cnt at 0.
